if_id_skid_stage: RTL
=====================

Name: if_id_skid_stage

Overview:
Parametrised IF/ID pipeline stage with a valid/ready handshake, replacing the plain write-enabled PC/instruction register.
- Holds one PC/instruction pair plus one skid entry.
- Upstream ready is registered, so no combinational path runs from the decode stall (out_ready) back to fetch.
- A flush kills all in-flight entries for branch/jump redirects.
- Sits between fetch and decode.

Parameters:
PC_W, 32, width of PC field
INST_W, 32, width of instruction field
NOP_INST, 32'h00000013, instruction value driven when stage holds no valid entry
CNT_W, 16, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  fetch presents a valid PC/inst
in_ready  output  1  stage can accept; = !skid_valid && !rst
in_pc  input  PC_W  fetched PC
in_inst  input  INST_W  fetched instruction
flush  input  1  discard all entries (redirect)
out_valid  output  1  main entry valid toward decode
out_ready  input  1  decode accepts (low = stall)
out_pc  output  PC_W  PC_ID; 0 when !out_valid
out_inst  output  INST_W  inst_ID; NOP_INST when !out_valid

Behaviour:
- Reset (async assert, sync-safe deassert by system): main_valid=0, skid_valid=0, data regs=0.
  - Outputs during and after reset: out_valid=0, out_pc=0, out_inst=NOP_INST, in_ready=0 while rst=1 and 1 after.
  - Reset mid-transfer drops all entries.
- Events per cycle:
  - accept = in_valid && in_ready
  - issue = out_valid && out_ready
  - out_ready is ignored when out_valid=0.
- States, from {main_valid, skid_valid}:
  - EMPTY: accept -> main<=in, FULL; else EMPTY.
  - FULL:
    - accept && issue -> main<=in, FULL.
    - accept && !issue -> skid<=in, SKID.
    - !accept && issue -> EMPTY.
    - neither -> hold.
  - SKID: in_ready=0, so no accept.
    - issue -> main<=skid, skid_valid=0, FULL.
    - else hold; main and skid unchanged.
- flush has top priority. At the next edge main_valid=0 and skid_valid=0, and any same-cycle accept is discarded (in_ready not gated by flush). An issue in the flush cycle still counts as completed for decode.
- Latency: 1 cycle from accept to out_valid when EMPTY or when issuing in FULL.
- Throughput: 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO. The skid entry is always younger than main.
- Data regs load only on accept/shift; no toggling otherwise.
- Outputs are masked by main_valid: out_pc=0 and out_inst=NOP_INST when invalid.
- Equivalence with the old register: in_valid=1 and out_ready=IF_ID_Write gives the old stall behaviour, plus the skid capture.

Optional Feature:
Macro PERF_CNT_EN.
- Defined: adds outputs stall_cnt [CNT_W] and flush_kill_cnt [CNT_W], both reset to 0 and saturating at all-ones.
  - stall_cnt increments on each cycle with out_valid && !out_ready.
  - flush_kill_cnt adds the number of valid entries killed by a flush: 0, 1 or 2. An entry issuing in the same cycle is not counted as killed.
- Undefined: ports and logic absent; the handshake behaviour is identical.

Test Plan:
1. Reset then stream: rst pulse, in_valid=1, PCs 0x0,0x4,0x8, out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles starting 1 cycle after each accept; in_ready stays 1.
2. Stall with skid: FULL holding 0x10 with out_ready=0, present 0x14 -> skid captures 0x14, in_ready=0. out_valid holds 0x10 until out_ready=1, then 0x14 next cycle, then in_ready=1.
3. Flush in SKID state (0x20 main, 0x24 skid) plus in_valid=1 0x28 -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0, 0x28 not captured. With PERF_CNT_EN, flush_kill_cnt +=2.
4. Async reset mid-SKID: assert rst between edges -> out_valid=0 immediately, in_ready=0. After release, in_ready=1 and the stage is empty.
5. Idle handshake: out_ready=1, in_valid=0 for 5 cycles -> out_valid=0, outputs masked, no state change; out_ready toggling while empty has no effect.
6. PERF_CNT_EN saturation with CNT_W=4: stall 20 cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: one main entry plus one skid entry, valid/ready on both sides.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module if_id_skid_stage #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
`ifdef PERF_CNT_EN
   ,
   parameter int                CNT_W    = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_kill_cnt
`endif
);

   // State encodes {main_valid, skid_valid}; 2'b01 cannot occur.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b10,
      SKID  = 2'b11
   } state_t;

   state_t            state_r;
   state_t            state_next;
   logic [PC_W-1:0]   main_pc_r;
   logic [INST_W-1:0] main_inst_r;
   logic [PC_W-1:0]   skid_pc_r;
   logic [INST_W-1:0] skid_inst_r;
   logic              main_valid;
   logic              skid_valid;
   logic              accept;
   logic              issue;
   logic              load_main;
   logic              shift_skid;
   logic              load_skid;

   assign main_valid = (state_r != EMPTY);
   assign skid_valid = (state_r == SKID);
   // in_ready depends only on registered state (and reset), never on out_ready.
   assign in_ready   = ~skid_valid & ~rst;
   assign accept     = in_valid & in_ready;
   assign issue      = main_valid & out_ready;

   assign out_valid  = main_valid;
   assign out_pc     = main_valid ? main_pc_r : {PC_W{1'b0}};
   assign out_inst   = main_valid ? main_inst_r : NOP_INST;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_next;
      end
   end

   // Next state and data-register load enables; flush overrides everything.
   always_comb begin
      state_next = state_r;
      load_main  = 1'b0;
      shift_skid = 1'b0;
      load_skid  = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept) begin
                  load_main  = 1'b1;
                  state_next = FULL;
               end else begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (accept && issue) begin
                  load_main  = 1'b1;
                  state_next = FULL;
               end else if (accept) begin
                  load_skid  = 1'b1;
                  state_next = SKID;
               end else if (issue) begin
                  state_next = EMPTY;
               end else begin
                  state_next = FULL;
               end
            end
            SKID: begin
               if (issue) begin
                  shift_skid = 1'b1;
                  state_next = FULL;
               end else begin
                  state_next = SKID;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Main data register: loads from fetch or from the skid entry only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_pc_r   <= {PC_W{1'b0}};
         main_inst_r <= {INST_W{1'b0}};
      end else if (load_main) begin
         main_pc_r   <= in_pc;
         main_inst_r <= in_inst;
      end else if (shift_skid) begin
         main_pc_r   <= skid_pc_r;
         main_inst_r <= skid_inst_r;
      end
   end

   // Skid data register: captures fetch when decode stalls with main occupied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_pc_r   <= {PC_W{1'b0}};
         skid_inst_r <= {INST_W{1'b0}};
      end else if (load_skid) begin
         skid_pc_r   <= in_pc;
         skid_inst_r <= in_inst;
      end
   end

`ifdef PERF_CNT_EN
   logic [1:0] kill_num;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // A main entry issuing during the flush cycle reached decode, so it is not killed.
   assign kill_num = flush ? ({1'b0, main_valid & ~issue} + {1'b0, skid_valid}) : 2'd0;

   // Saturating stall and flush-kill counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt      <= {CNT_W{1'b0}};
         flush_kill_cnt <= {CNT_W{1'b0}};
      end else begin
         stall_cnt      <= sat_add(stall_cnt, {1'b0, main_valid & ~out_ready});
         flush_kill_cnt <= sat_add(flush_kill_cnt, kill_num);
      end
   end
`endif

endmodule
